btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
Parametrised multi-channel debouncer for the board push-buttons: up, down, left, right and centre for the 2048 game. Per channel it provides:
- a 2-flop synchroniser;
- a stable-count filter;
- a debounced level;
- one-cycle press and release pulses;
- optional hold-to-auto-repeat press pulses.

It sits between the raw button pins and the game control FSM, and supersedes the single-channel level-only button debouncer.

Parameters:
N_BTN, 5, number of independent button channels
STABLE_CYCLES, 5, consecutive identical synchronised samples required to change the debounced level (>=1)
REPEAT_EN, 1, 1 enables auto-repeat press pulses while held; 0 disables
REPEAT_DELAY, 50_000_000, cycles of held level before the first repeat pulse (>=1)
REPEAT_PERIOD, 10_000_000, cycles between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn  input  N_BTN  raw, asynchronous, bouncing button inputs, active high
level  output  N_BTN  debounced level per channel
press  output  N_BTN  one-cycle pulse on debounced press and on each auto-repeat
release  output  N_BTN  one-cycle pulse on debounced release
any_press  output  1  OR-reduction of press, registered in the same cycle as press

Behaviour:
- Reset (async assert, sync-release tolerant):
  - sync flops, counters and level clear to 0.
  - press, release and any_press are 0; the repeat FSM is IDLE.
  - Reset mid-count discards all progress. No press pulse appears after reset for a button held through reset until STABLE_CYCLES are counted.
- Synchroniser: 2 flops per channel (s1, s2).
- Filter:
  - The counter width is clog2(STABLE_CYCLES+1).
  - If s2 == level, the counter clears.
  - If s2 != level, the counter increments.
  - When the counter reaches STABLE_CYCLES, level toggles and the counter clears on the same edge.
  - Any single disagreeing sample restarts the count (bounce rejection).
- Latency: edge 1 is the first edge sampling the new btn value. level changes on edge STABLE_CYCLES+2, which is edge 7 for the default.
- press/release:
  - Registered, asserted for exactly the first cycle in which level is new.
  - Never both high on one channel.
  - Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
- Repeat FSM per channel (only when REPEAT_EN=1; otherwise it stays in IDLE):
  - IDLE: on the edge level rises, go to DELAY and clear the repeat counter.
  - DELAY: the counter increments each cycle. When it equals REPEAT_DELAY-1, pulse press next cycle, clear the counter and go to REPEAT.
  - REPEAT: when the counter equals REPEAT_PERIOD-1, pulse press, clear the counter and stay in REPEAT.
  - Level falling in any state goes to IDLE immediately; no repeat pulse coincides with release.
- Repeat timing: the first repeat press is REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles.
- Repeat counter width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). The counter never wraps, because it is cleared at its terminal value.
- any_press: high in exactly the cycles where any press bit is high.

Decomposition:
- Package btn_pkg holds:
  - the repeat FSM state encoding (IDLE=2'd0, DELAY=2'd1, REPEAT=2'd2);
  - channel index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_CENTER=4;
  - a clog2-based width helper.
- Sub-module btn_debounce_chan implements one channel (sync, filter, edge pulses, repeat FSM). The top level generates N_BTN instances and the any_press OR.

Test Plan:
(Clock period 10 ns; STABLE_CYCLES=5, REPEAT_DELAY=20, REPEAT_PERIOD=8 for bench.)

1. Hold rst_n=0 with btn=5'b11111, release at t=100 ns -> level=0 and press=0 during reset. level[4:0] goes to 1 and press pulses once 7 edges after the first post-reset sample.
2. On btn[0], apply high 12 ns / low 17 ns / high 23 ns / low 14 ns / high, then hold 300 ns -> level[0] rises exactly once, 7 edges after the final rising edge. press[0] is a single 1-cycle pulse; no pulse occurs during the bounce.
3. btn[1] high for 4 cycles then low -> level[1], press[1] and release[1] all stay 0.
4. Hold btn[2] high for 60 cycles after press -> press[2] pulses at +0, +20, +28, +36, +44, +52 cycles relative to the first press. After btn[2] falls, release[2] pulses once 7 edges later and no further press pulses occur.
5. btn[0] and btn[3] rise on the same edge -> press[0] and press[3] are high in the same cycle and any_press is high for exactly that one cycle.
6. Assert rst_n low mid-count (3 stable samples into a press) -> all outputs are 0 immediately. After release with btn still high, the full 7-edge latency applies before press.

Source files
------------

// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the push-button debouncer: repeat FSM encoding,
// board channel indices and a counter-width helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
`timescale 1ns/1ps
// One button channel: 2-flop synchroniser, stable-count filter, registered
// press/release pulses and the hold-to-repeat FSM.
module btn_debounce_chan
    import btn_pkg::*;
#(
    parameter int STABLE_CYCLES = 5,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_o
);

    localparam int SW = cnt_width(STABLE_CYCLES + 1);
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic          s1_q, s1_d, s2_q, s2_d;
    logic          level_q, level_d;
    logic          press_q, press_d, release_q, release_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rpt_state_e    state_q, state_d;
    logic          rise, fall, rpt_pulse;

    // The count reaching STABLE_CYCLES is the toggle itself, so cnt never holds it.
    always_comb begin
        s1_d    = btn_i;
        s2_d    = s1_q;
        cnt_d   = '0;
        level_d = level_q;
        rise    = 1'b0;
        fall    = 1'b0;
        if (s2_q != level_q) begin
            if (cnt_q == STABLE_LAST) begin
                level_d = ~level_q;
                rise    = ~level_q;
                fall    = level_q;
            end else begin
                cnt_d = cnt_q + SW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rcnt_d    = rcnt_q;
        rpt_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && REPEAT_EN) begin
                    state_d = DELAY;
                    rcnt_d  = '0;
                end
            end
            DELAY: begin
                if (rcnt_q == DELAY_LAST) begin
                    rpt_pulse = 1'b1;
                    rcnt_d    = '0;
                    state_d   = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            REPEAT: begin
                if (rcnt_q == PERIOD_LAST) begin
                    rpt_pulse = 1'b1;
                    rcnt_d    = '0;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A release always wins over a repeat due on the same edge.
        if (fall) begin
            state_d   = IDLE;
            rcnt_d    = '0;
            rpt_pulse = 1'b0;
        end
        press_d   = rise | rpt_pulse;
        release_d = fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rcnt_q    <= '0;
            state_q   <= IDLE;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            rcnt_q    <= rcnt_d;
            state_q   <= state_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/btn_debounce_multi.sv
`timescale 1ns/1ps
// Multi-channel button debouncer for the board push-buttons. The release
// output is called release_pulse because "release" is a reserved word.
module btn_debounce_multi
    import btn_pkg::*;
#(
    parameter int N_BTN         = 5,
    parameter int STABLE_CYCLES = 5,
    parameter bit REPEAT_EN     = 1'b1,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic             any_press
);

    logic [N_BTN-1:0] press_next;
    logic             any_press_q, any_press_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_i       (btn[i]),
            .level_o     (level[i]),
            .press_o     (press[i]),
            .release_o   (release_pulse[i]),
            .press_next_o(press_next[i])
        );
    end

    // Registered from the per-channel next-press terms so it lines up with press.
    always_comb begin
        any_press_d = |press_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
`timescale 1ns/1ps
// Bench for btn_debounce_multi: directed vector table, hand sequences for
// reset/bounce/simultaneity, and random stimulus against a window-based model.
module tb_btn_debounce_multi;
    import btn_pkg::*;

    localparam int N = 5;
    localparam int S = 5;
    localparam bit REPEAT_EN = 1'b1;
    localparam int D = 20;
    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] level, press, release_pulse;
    logic         any_press;

    int checks = 0;
    int failures = 0;

    btn_debounce_multi #(
        .N_BTN(N), .STABLE_CYCLES(S), .REPEAT_EN(REPEAT_EN),
        .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .level(level), .press(press),
        .release_pulse(release_pulse), .any_press(any_press)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: the level flips once the last S synchronised samples
    // all disagree with it; repeats are derived from cycles held since the press.
    logic [1:0]   m_samp [N];
    logic [S-1:0] m_win  [N];
    int           m_held [N];
    logic [N-1:0] m_level = '0, m_press = '0, m_rel = '0;

    initial begin
        for (int c = 0; c < N; c++) begin
            m_samp[c] = '0;
            m_win[c]  = '0;
            m_held[c] = 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                m_samp[c] <= '0;
                m_win[c]  <= '0;
                m_held[c] <= 0;
            end
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                logic         used, lv, p, r;
                logic [S-1:0] win;
                int           held;
                used = m_samp[c][1];
                win  = {m_win[c][S-2:0], used};
                lv   = m_level[c];
                held = m_held[c];
                p    = 1'b0;
                r    = 1'b0;
                if ($countones(win ^ {S{lv}}) == S) begin
                    lv   = ~lv;
                    held = 0;
                    p    = lv;
                    r    = ~lv;
                end else if (lv) begin
                    held++;
                    if (REPEAT_EN && (held == D || (held > D && (held - D) % P == 0)))
                        p = 1'b1;
                end
                m_samp[c]  <= {m_samp[c][0], btn[c]};
                m_win[c]   <= win;
                m_level[c] <= lv;
                m_held[c]  <= held;
                m_press[c] <= p;
                m_rel[c]   <= r;
            end
        end
    end

    always @(negedge clk) begin
        check("mdl_level", level, m_level);
        check("mdl_press", press, m_press);
        check("mdl_release", release_pulse, m_rel);
        check("mdl_any_press", any_press, |m_press);
    end

    typedef struct {
        int ch;
        int high_cyc;
        int exp_press;
        int exp_rel;
        bit exp_lvl;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{BTN_DOWN,   4,  0, 0, 1'b0};
        vecs[1] = '{BTN_UP,     5,  1, 1, 1'b1};
        vecs[2] = '{BTN_RIGHT,  20, 1, 1, 1'b1};
        vecs[3] = '{BTN_RIGHT,  21, 2, 1, 1'b1};
        vecs[4] = '{BTN_LEFT,   28, 2, 1, 1'b1};
        vecs[5] = '{BTN_LEFT,   29, 3, 1, 1'b1};
        vecs[6] = '{BTN_LEFT,   60, 6, 1, 1'b1};
        vecs[7] = '{BTN_CENTER, 1,  0, 0, 1'b0};

        // Buttons held through reset
        btn = 5'b11111;
        #50;
        check("rst_level", level, 5'b00000);
        check("rst_press", press, 5'b00000);
        check("rst_any", any_press, 1'b0);
        #50;
        rst_n = 1'b1;
        edges(6);
        check("t1_level_pre", level, 5'b00000);
        edges(1);
        check("t1_level", level, 5'b11111);
        check("t1_press", press, 5'b11111);
        check("t1_any", any_press, 1'b1);
        edges(1);
        check("t1_press_end", press, 5'b00000);
        btn = '0;
        edges(30);

        // Bounce on the up button, then a clean hold
        @(negedge clk);
        btn[BTN_UP] = 1'b1;
        #12 btn[BTN_UP] = 1'b0;
        #17 btn[BTN_UP] = 1'b1;
        #23 btn[BTN_UP] = 1'b0;
        #14 btn[BTN_UP] = 1'b1;
        edges(6);
        check("t2_level_pre", level[BTN_UP], 1'b0);
        edges(1);
        check("t2_level", level[BTN_UP], 1'b1);
        check("t2_press", press[BTN_UP], 1'b1);
        edges(1);
        check("t2_press_end", press[BTN_UP], 1'b0);
        edges(22);
        btn[BTN_UP] = 1'b0;
        edges(30);
        check("t2_level_end", level[BTN_UP], 1'b0);

        // Directed pulse-count table
        for (int k = 0; k < 8; k++) begin
            int  npress, nrel;
            bit  seen;
            npress = 0;
            nrel   = 0;
            seen   = 1'b0;
            btn[vecs[k].ch] = 1'b1;
            for (int i = 0; i < vecs[k].high_cyc + 30; i++) begin
                edges(1);
                if (i == vecs[k].high_cyc - 1) btn[vecs[k].ch] = 1'b0;
                npress += int'(press[vecs[k].ch]);
                nrel   += int'(release_pulse[vecs[k].ch]);
                if (level[vecs[k].ch]) seen = 1'b1;
            end
            check($sformatf("vec%0d_press_cnt", k), npress, vecs[k].exp_press);
            check($sformatf("vec%0d_rel_cnt", k), nrel, vecs[k].exp_rel);
            check($sformatf("vec%0d_level_seen", k), seen, vecs[k].exp_lvl);
            check($sformatf("vec%0d_level_end", k), level, 5'b00000);
        end

        // Simultaneous press on up and right
        btn[BTN_UP] = 1'b1;
        btn[BTN_RIGHT] = 1'b1;
        edges(6);
        check("t5_any_pre", any_press, 1'b0);
        edges(1);
        check("t5_press", press, 5'b01001);
        check("t5_any", any_press, 1'b1);
        edges(1);
        check("t5_any_end", any_press, 1'b0);
        btn = '0;
        edges(30);

        // Reset part-way through a press, centre already high
        btn[BTN_CENTER] = 1'b1;
        edges(10);
        check("t6_center_level", level[BTN_CENTER], 1'b1);
        btn[BTN_DOWN] = 1'b1;
        edges(5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_level", level, 5'b00000);
        check("t6_rst_press", press, 5'b00000);
        check("t6_rst_release", release_pulse, 5'b00000);
        check("t6_rst_any", any_press, 1'b0);
        #3 rst_n = 1'b1;
        edges(6);
        check("t6_level_pre", level, 5'b00000);
        edges(1);
        check("t6_level", level, 5'b10010);
        check("t6_press", press, 5'b10010);
        btn = '0;
        edges(30);

        // Random bouncing with occasional asynchronous resets
        for (int i = 0; i < 1600; i++) begin
            edges(1);
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, (i < 800) ? 7 : 39) == 0) btn[c] = ~btn[c];
            end
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        btn = '0;
        edges(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
